scoreboard_queue: RTL and testbench

SCOREBOARD_QUEUE -- requirements
Module: scoreboard_queue

---
 rtl/scoreboard_queue.sv | 122 ++++++++++++
 tb/tb_scoreboard_queue.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_queue.sv
// In-order completion scoreboard. Entries are allocated at the tail, completed out of
// order by the writeback ports, and retired in order from the head.
module scoreboard_queue #(
  parameter int DEPTH    = 4,
  parameter int WB_PORTS = 2,
  parameter int XLEN     = 32,
  localparam int IDX     = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     alloc_valid_i,
  output logic                     alloc_ready_o,
  input  logic [4:0]               alloc_rd_i,
  input  logic [XLEN-1:0]          alloc_pc_i,
  output logic [IDX-1:0]           alloc_idx_o,
  input  logic [WB_PORTS-1:0]      wb_valid_i,
  input  logic [WB_PORTS*IDX-1:0]  wb_idx_i,
  input  logic [WB_PORTS*XLEN-1:0] wb_data_i,
  output logic                     commit_valid_o,
  input  logic                     commit_ack_i,
  output logic [IDX-1:0]           commit_idx_o,
  output logic [4:0]               commit_rd_o,
  output logic [XLEN-1:0]          commit_pc_o,
  output logic [XLEN-1:0]          commit_data_o,
  output logic [IDX:0]             count_o
);

  logic [IDX:0]      r_head;
  logic [IDX:0]      r_tail;
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_done;
  logic [4:0]        r_rd   [DEPTH];
  logic [XLEN-1:0]   r_pc   [DEPTH];
  logic [XLEN-1:0]   r_data [DEPTH];

  logic [IDX-1:0]    w_head_idx;
  logic [IDX-1:0]    w_tail_idx;
  logic              w_full;
  logic              w_alloc;
  logic              w_commit;
  logic [DEPTH-1:0]  w_alloc_sel;
  logic [DEPTH-1:0]  w_commit_sel;
  logic [DEPTH-1:0]  w_wb_hit;
  logic [DEPTH-1:0]  w_wb_set;
  logic [XLEN-1:0]   w_wb_data [DEPTH];

  assign w_head_idx = r_head[IDX-1:0];
  assign w_tail_idx = r_tail[IDX-1:0];
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IDX] != r_tail[IDX]);
  assign w_alloc    = alloc_valid_i && !w_full;

  assign alloc_ready_o  = !w_full;
  assign alloc_idx_o    = w_tail_idx;
  assign commit_valid_o = r_valid[w_head_idx] && r_done[w_head_idx];
  assign w_commit       = commit_valid_o && commit_ack_i;
  assign commit_idx_o   = w_head_idx;
  assign commit_rd_o    = r_rd[w_head_idx];
  assign commit_pc_o    = r_pc[w_head_idx];
  assign commit_data_o  = r_data[w_head_idx];
  assign count_o        = r_tail - r_head;

  // Per-entry writeback select; scanning ports high to low lets the lowest port win.
  // An entry being retired this cycle, or not yet allocated, ignores writebacks.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign w_alloc_sel[gi]  = w_alloc && (w_tail_idx == IDX'(gi));
    assign w_commit_sel[gi] = w_commit && (w_head_idx == IDX'(gi));

    always_comb begin
      w_wb_hit[gi]  = 1'b0;
      w_wb_data[gi] = '0;
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && (wb_idx_i[p*IDX +: IDX] == IDX'(gi))) begin
          w_wb_hit[gi]  = 1'b1;
          w_wb_data[gi] = wb_data_i[p*XLEN +: XLEN];
        end
      end
    end

    assign w_wb_set[gi] = w_wb_hit[gi] && r_valid[gi] && !w_commit_sel[gi];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      if (w_alloc)  r_tail <= r_tail + 1'b1;
      if (w_commit) r_head <= r_head + 1'b1;
      for (int e = 0; e < DEPTH; e++) begin
        if (w_alloc_sel[e]) begin
          r_valid[e] <= 1'b1;
          r_done[e]  <= 1'b0;
        end else if (w_commit_sel[e]) begin
          r_valid[e] <= 1'b0;
          r_done[e]  <= 1'b0;
        end else if (w_wb_set[e]) begin
          r_done[e]  <= 1'b1;
        end
      end
    end
  end

  // Payload storage carries no reset; it is only observed behind valid/done.
  always_ff @(posedge clk_i) begin
    if (w_alloc) begin
      r_rd[w_tail_idx] <= alloc_rd_i;
      r_pc[w_tail_idx] <= alloc_pc_i;
    end
    for (int e = 0; e < DEPTH; e++) begin
      if (w_wb_set[e]) r_data[e] <= w_wb_data[e];
    end
  end

endmodule

// File: tb/tb_scoreboard_queue.sv
// Directed and randomized bench for scoreboard_queue against an entry-array queue model.
module tb_scoreboard_queue;
  localparam int DEPTH    = 4;
  localparam int WB_PORTS = 2;
  localparam int XLEN     = 32;
  localparam int IDX      = $clog2(DEPTH);

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic                     flush_i;
  logic                     alloc_valid_i;
  logic                     alloc_ready_o;
  logic [4:0]               alloc_rd_i;
  logic [XLEN-1:0]          alloc_pc_i;
  logic [IDX-1:0]           alloc_idx_o;
  logic [WB_PORTS-1:0]      wb_valid_i;
  logic [WB_PORTS*IDX-1:0]  wb_idx_i;
  logic [WB_PORTS*XLEN-1:0] wb_data_i;
  logic                     commit_valid_o;
  logic                     commit_ack_i;
  logic [IDX-1:0]           commit_idx_o;
  logic [4:0]               commit_rd_o;
  logic [XLEN-1:0]          commit_pc_o;
  logic [XLEN-1:0]          commit_data_o;
  logic [IDX:0]             count_o;

  scoreboard_queue #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_rd_i(alloc_rd_i), .alloc_pc_i(alloc_pc_i), .alloc_idx_o(alloc_idx_o),
    .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_data_i(wb_data_i),
    .commit_valid_o(commit_valid_o), .commit_ack_i(commit_ack_i),
    .commit_idx_o(commit_idx_o), .commit_rd_o(commit_rd_o),
    .commit_pc_o(commit_pc_o), .commit_data_o(commit_data_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: occupied entries are the m_cnt slots starting at m_head (mod DEPTH).
  int              m_head;
  int              m_cnt;
  bit              m_valid [DEPTH];
  bit              m_done  [DEPTH];
  logic [4:0]      m_rd    [DEPTH];
  logic [XLEN-1:0] m_pc    [DEPTH];
  logic [XLEN-1:0] m_data  [DEPTH];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_head = 0;
    m_cnt  = 0;
    for (int e = 0; e < DEPTH; e++) begin
      m_valid[e] = 1'b0;
      m_done[e]  = 1'b0;
    end
  endtask

  function automatic int m_tail();
    return (m_head + m_cnt) % DEPTH;
  endfunction

  function automatic bit m_cv();
    return m_valid[m_head] && m_done[m_head];
  endfunction

  task automatic check_outputs();
    check_eq("count", 64'(count_o), 64'(m_cnt));
    check_eq("ready", 64'(alloc_ready_o), 64'(m_cnt < DEPTH));
    check_eq("alloc_idx", 64'(alloc_idx_o), 64'(m_tail()));
    check_eq("commit_valid", 64'(commit_valid_o), 64'(m_cv()));
    if (m_cv()) begin
      check_eq("commit_idx", 64'(commit_idx_o), 64'(m_head));
      check_eq("commit_rd", 64'(commit_rd_o), 64'(m_rd[m_head]));
      check_eq("commit_pc", 64'(commit_pc_o), 64'(m_pc[m_head]));
      check_eq("commit_data", 64'(commit_data_o), 64'(m_data[m_head]));
    end
  endtask

  task automatic model_update();
    bit do_commit, do_alloc;
    int idx, tl;
    if (flush_i) begin
      model_reset();
      return;
    end
    do_commit = m_cv() && commit_ack_i;
    do_alloc  = alloc_valid_i && (m_cnt < DEPTH);
    if (do_commit)
      $display("commit idx=%0d rd=%0d pc=0x%h data=0x%h", m_head, m_rd[m_head], m_pc[m_head], m_data[m_head]);
    // Highest port applied first so the lowest-numbered port ends up holding the entry.
    for (int p = WB_PORTS - 1; p >= 0; p--) begin
      idx = int'(wb_idx_i[p*IDX +: IDX]);
      if (wb_valid_i[p] && m_valid[idx] && !(do_commit && idx == m_head)) begin
        m_done[idx] = 1'b1;
        m_data[idx] = wb_data_i[p*XLEN +: XLEN];
      end
    end
    tl = m_tail();
    if (do_alloc) begin
      m_valid[tl] = 1'b1;
      m_done[tl]  = 1'b0;
      m_rd[tl]    = alloc_rd_i;
      m_pc[tl]    = alloc_pc_i;
      m_cnt++;
    end
    if (do_commit) begin
      m_valid[m_head] = 1'b0;
      m_done[m_head]  = 1'b0;
      m_head = (m_head + 1) % DEPTH;
      m_cnt--;
    end
  endtask

  task automatic step();
    check_outputs();
    model_update();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i       = 1'b0;
    alloc_valid_i = 1'b0;
    alloc_rd_i    = '0;
    alloc_pc_i    = '0;
    wb_valid_i    = '0;
    wb_idx_i      = '0;
    wb_data_i     = '0;
    commit_ack_i  = 1'b0;
  endtask

  task automatic do_alloc(input int rd);
    alloc_valid_i = 1'b1;
    alloc_rd_i    = 5'(rd);
    alloc_pc_i    = 32'h1000 + 32'(rd * 4);
  endtask

  task automatic do_wb(input int port, input int idx, input logic [XLEN-1:0] data);
    wb_valid_i[port]              = 1'b1;
    wb_idx_i[port*IDX +: IDX]     = IDX'(idx);
    wb_data_i[port*XLEN +: XLEN]  = data;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_count"}, 64'(count_o), 64'd0);
    check_eq({tag, "_ready"}, 64'(alloc_ready_o), 64'd1);
    check_eq({tag, "_aidx"}, 64'(alloc_idx_o), 64'd0);
    check_eq({tag, "_cv"}, 64'(commit_valid_o), 64'd0);
  endtask

  initial begin
    idle();
    model_reset();
    rst_ni = 1'b0;
    #12;
    check_reset_state("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Fill to capacity, then offer a fifth allocation.
    for (int k = 0; k < DEPTH; k++) begin
      idle();
      do_alloc(k + 1);
      check_eq("fill_idx", 64'(alloc_idx_o), 64'(k));
      step();
    end
    idle();
    do_alloc(9);
    check_eq("full_ready", 64'(alloc_ready_o), 64'd0);
    step();
    check_eq("full_count", 64'(count_o), 64'd4);

    // Out-of-order completion: idx2 then idx0.
    idle();
    do_wb(0, 2, 32'h22);
    step();
    idle();
    check_eq("ooo_blk2", 64'(commit_valid_o), 64'd0);
    do_wb(0, 0, 32'h11);
    check_eq("ooo_nobypass", 64'(commit_valid_o), 64'd0);
    step();
    idle();
    check_eq("ooo_cv0", 64'(commit_valid_o), 64'd1);
    check_eq("ooo_idx0", 64'(commit_idx_o), 64'd0);
    check_eq("ooo_data0", 64'(commit_data_o), 64'h11);
    commit_ack_i = 1'b1;
    step();
    idle();
    check_eq("idx1_blk", 64'(commit_valid_o), 64'd0);

    // Port conflict on idx1: port 0 wins.
    do_wb(0, 1, 32'hAAAA);
    do_wb(1, 1, 32'hBBBB);
    step();
    idle();
    check_eq("conf_cv", 64'(commit_valid_o), 64'd1);
    check_eq("conf_idx", 64'(commit_idx_o), 64'd1);
    check_eq("conf_data", 64'(commit_data_o), 64'hAAAA);

    // Refill to full, then commit and allocate together.
    do_alloc(12);
    check_eq("refill_idx", 64'(alloc_idx_o), 64'd0);
    step();
    idle();
    check_eq("refull_count", 64'(count_o), 64'd4);
    commit_ack_i = 1'b1;
    do_alloc(13);
    check_eq("fullc_ready", 64'(alloc_ready_o), 64'd0);
    step();
    idle();
    check_eq("fullc_count", 64'(count_o), 64'd3);
    check_eq("fullc_freed", 64'(alloc_idx_o), 64'd1);
    do_alloc(14);
    step();
    idle();
    check_eq("fullc_count2", 64'(count_o), 64'd4);

    // Retire one, then flush with concurrent writeback and allocation.
    commit_ack_i = 1'b1;
    step();
    idle();
    check_eq("preflush_count", 64'(count_o), 64'd3);
    flush_i = 1'b1;
    do_wb(0, 3, 32'h33);
    do_alloc(15);
    step();
    idle();
    check_eq("flush_count", 64'(count_o), 64'd0);
    check_eq("flush_cv", 64'(commit_valid_o), 64'd0);
    check_eq("flush_aidx", 64'(alloc_idx_o), 64'd0);

    // Six alloc/complete/commit rounds to cross the wrap point.
    for (int k = 0; k < 6; k++) begin
      idle();
      do_alloc(20 + k);
      check_eq("wrap_idx", 64'(alloc_idx_o), 64'(k % DEPTH));
      step();
      idle();
      do_wb(k % WB_PORTS, k % DEPTH, 32'(32'hC000 + k));
      step();
      idle();
      commit_ack_i = 1'b1;
      step();
      idle();
      check_eq("wrap_empty", 64'(count_o), 64'd0);
    end

    // Randomized traffic with an asynchronous reset in the middle.
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) begin
        idle();
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_state("midreset");
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        do_alloc(31);
        check_eq("post_reset_idx", 64'(alloc_idx_o), 64'd0);
        step();
      end
      idle();
      flush_i       = ($urandom_range(0, 49) == 0);
      alloc_valid_i = ($urandom_range(0, 9) < 6);
      alloc_rd_i    = 5'($urandom);
      alloc_pc_i    = $urandom;
      commit_ack_i  = ($urandom_range(0, 9) < 6);
      for (int p = 0; p < WB_PORTS; p++) begin
        int idx;
        if (m_cnt > 0 && $urandom_range(0, 3) != 0)
          idx = (m_head + int'($urandom_range(0, m_cnt - 1))) % DEPTH;
        else
          idx = int'($urandom_range(0, DEPTH - 1));
        if ($urandom_range(0, 1) == 1) do_wb(p, idx, $urandom);
      end
      step();
    end
    idle();
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
